// File: rtl/down_counter_4_bit.sv
// 4-bit synchronous down counter with parallel load, count enable,
// combinational borrow-out for cascading, and a selectable terminal-count
// behaviour: wrap to all-ones (MODE = 0) or reload the last loaded value
// (MODE = 1). DONE is a registered one-cycle pulse per terminal count.
module down_counter_4_bit #(
    parameter int unsigned WIDTH = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             EN,
    input  logic             LOAD,
    input  logic [WIDTH-1:0] D_IN,
    input  logic             MODE,
    output logic [WIDTH-1:0] Q,
    output logic             BO,
    output logic             DONE
);

    // Reload value, captured only on LOAD and cleared only by reset.
    logic [WIDTH-1:0] rld;
    logic             at_zero;

    assign at_zero = (Q == '0);

    // Borrow-out: this stage is about to pass through zero on the next edge.
    // Suppressed during reset and during a load so a cascaded stage does
    // not decrement on a cycle where this stage is not really counting.
    always_comb begin
        BO = RESET & EN & ~LOAD & at_zero;
    end

    // Count register, reload register and terminal-count pulse.
    // Priority: reset, then load, then enable, then hold.
    always_ff @(posedge CLK) begin
        if (!RESET) begin
            Q    <= '0;
            rld  <= '0;
            DONE <= 1'b0;
        end else if (LOAD) begin
            Q    <= D_IN;
            rld  <= D_IN;
            DONE <= 1'b0;
        end else if (EN) begin
            if (at_zero) begin
                // MODE is sampled here, so a change only matters at the
                // next terminal count.
                Q    <= MODE ? rld : '1;
                DONE <= 1'b1;
            end else begin
                Q    <= Q - 1'b1;
                DONE <= 1'b0;
            end
        end else begin
            DONE <= 1'b0;
        end
    end

endmodule

// File: tb/tb_down_counter_4_bit.sv
// Self-checking bench for down_counter_4_bit: a single stage driven from a
// vector table and hand sequences, plus a two-stage cascade.
module tb_down_counter_4_bit;

    logic       CLK = 1'b0;
    always #5 CLK = ~CLK;

    // Single-stage DUT signals
    logic       rst, en, load, mode;
    logic [3:0] d, q;
    logic       bo, done;

    // Cascade signals
    logic       c_rst, c_en, c_load;
    logic [7:0] c_d;
    logic [3:0] lo_q, hi_q;
    logic       lo_bo, hi_bo, lo_done, hi_done;

    down_counter_4_bit #(.WIDTH(4)) u_dut (
        .CLK(CLK), .RESET(rst), .EN(en), .LOAD(load), .D_IN(d), .MODE(mode),
        .Q(q), .BO(bo), .DONE(done)
    );

    down_counter_4_bit #(.WIDTH(4)) u_lo (
        .CLK(CLK), .RESET(c_rst), .EN(c_en), .LOAD(c_load), .D_IN(c_d[3:0]),
        .MODE(1'b0), .Q(lo_q), .BO(lo_bo), .DONE(lo_done)
    );

    down_counter_4_bit #(.WIDTH(4)) u_hi (
        .CLK(CLK), .RESET(c_rst), .EN(lo_bo), .LOAD(c_load), .D_IN(c_d[7:4]),
        .MODE(1'b0), .Q(hi_q), .BO(hi_bo), .DONE(hi_done)
    );

    int total = 0;
    int bad   = 0;

    typedef struct {
        string      name;
        logic       casc;
        logic [7:0] q;
        logic       done;
    } sb_t;
    sb_t sb[$];

    typedef struct {
        logic       rst, en, load, mode;
        logic [3:0] d;
        logic       bo;
        logic [3:0] q;
        logic       done;
    } vec_t;
    vec_t tbl[28];

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Pop one expectation after the edge and compare it with the DUT state.
    task automatic pop_compare();
        sb_t        e;
        logic [7:0] aq;
        logic       ad;
        if (sb.size() == 0) begin
            total++;
            bad++;
            $display("FAIL scoreboard: got empty expected entry");
            return;
        end
        e  = sb.pop_front();
        aq = e.casc ? {hi_q, lo_q} : {4'h0, q};
        ad = e.casc ? hi_done : done;
        check({e.name, ".q"}, aq, e.q);
        check({e.name, ".done"}, {7'd0, ad}, {7'd0, e.done});
    endtask

    // Drive one cycle on the single stage: BO checked before the edge,
    // Q/DONE expectation queued and checked after it.
    task automatic step(input string nm, input logic r, input logic e, input logic l,
                        input logic m, input logic [3:0] dv, input logic ebo,
                        input logic [3:0] eq, input logic edone);
        sb_t s;
        rst = r; en = e; load = l; mode = m; d = dv;
        #1;
        check({nm, ".bo"}, {7'd0, bo}, {7'd0, ebo});
        s.name = nm; s.casc = 1'b0; s.q = {4'h0, eq}; s.done = edone;
        sb.push_back(s);
        @(posedge CLK);
        #1;
        pop_compare();
        @(negedge CLK);
    endtask

    task automatic casc_step(input string nm, input logic r, input logic e, input logic l,
                             input logic [7:0] dv, input logic elbo, input logic ehbo,
                             input logic [7:0] eq, input logic ehdone);
        sb_t s;
        c_rst = r; c_en = e; c_load = l; c_d = dv;
        #1;
        check({nm, ".lo_bo"}, {7'd0, lo_bo}, {7'd0, elbo});
        check({nm, ".hi_bo"}, {7'd0, hi_bo}, {7'd0, ehbo});
        s.name = nm; s.casc = 1'b1; s.q = eq; s.done = ehdone;
        sb.push_back(s);
        @(posedge CLK);
        #1;
        pop_compare();
        @(negedge CLK);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [3:0] cur;

        // rst en ld md  d     bo    q     done
        tbl = '{
            '{1'b0,1'b1,1'b1,1'b0,4'h9, 1'b0,4'h0,1'b0},  // reset holds off load/en
            '{1'b0,1'b1,1'b1,1'b0,4'h9, 1'b0,4'h0,1'b0},
            '{1'b1,1'b0,1'b0,1'b0,4'h0, 1'b0,4'h0,1'b0},  // released, idle
            '{1'b1,1'b0,1'b0,1'b0,4'h0, 1'b0,4'h0,1'b0},
            '{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b1,4'hF,1'b1},  // first count wraps
            '{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b0,4'hE,1'b0},
            '{1'b1,1'b1,1'b1,1'b1,4'h3, 1'b0,4'h3,1'b0},  // load 3, auto-reload
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h2,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h1,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h0,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b1,4'h3,1'b1},  // reload
            '{1'b1,1'b0,1'b0,1'b1,4'h0, 1'b0,4'h3,1'b0},  // EN toggling
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h2,1'b0},
            '{1'b1,1'b0,1'b0,1'b1,4'h0, 1'b0,4'h2,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h1,1'b0},
            '{1'b1,1'b0,1'b0,1'b1,4'h0, 1'b0,4'h1,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h0,1'b0},
            '{1'b1,1'b0,1'b0,1'b1,4'h0, 1'b0,4'h0,1'b0},  // zero, EN low: no borrow
            '{1'b1,1'b1,1'b1,1'b1,4'h7, 1'b0,4'h7,1'b0},  // load collides with tc
            '{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b0,4'h6,1'b0},
            '{1'b1,1'b0,1'b1,1'b1,4'h0, 1'b0,4'h0,1'b0},  // load 0: no DONE
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b1,4'h0,1'b1},  // RLD=0: divide by 1
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b1,4'h0,1'b1},
            '{1'b1,1'b0,1'b0,1'b1,4'h0, 1'b0,4'h0,1'b0},
            '{1'b1,1'b0,1'b1,1'b1,4'h2, 1'b0,4'h2,1'b0},  // MODE sampled at tc only
            '{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b0,4'h1,1'b0},
            '{1'b1,1'b1,1'b0,1'b1,4'h0, 1'b0,4'h0,1'b0},
            '{1'b1,1'b1,1'b0,1'b0,4'h0, 1'b1,4'hF,1'b1}
        };

        rst = 1'b0; en = 1'b0; load = 1'b0; mode = 1'b0; d = 4'h0;
        c_rst = 1'b0; c_en = 1'b0; c_load = 1'b0; c_d = 8'h00;
        @(negedge CLK);

        for (int i = 0; i < 28; i++) begin
            step($sformatf("vec%0d", i), tbl[i].rst, tbl[i].en, tbl[i].load, tbl[i].mode,
                 tbl[i].d, tbl[i].bo, tbl[i].q, tbl[i].done);
        end

        // Free-run over a full period plus one wrap.
        step("fr_load0", 1'b1, 1'b0, 1'b1, 1'b0, 4'h0, 1'b0, 4'h0, 1'b0);
        cur = 4'h0;
        for (int i = 0; i < 17; i++) begin
            step($sformatf("fr%0d", i), 1'b1, 1'b1, 1'b0, 1'b0, 4'h0,
                 cur == 4'h0, cur - 4'h1, cur == 4'h0);
            cur = cur - 4'h1;
        end

        // Reset mid-operation in auto-reload mode.
        step("rm_load5", 1'b1, 1'b0, 1'b1, 1'b1, 4'h5, 1'b0, 4'h5, 1'b0);
        step("rm_c0",    1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h4, 1'b0);
        step("rm_c1",    1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h3, 1'b0);
        step("rm_c2",    1'b1, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h2, 1'b0);
        step("rm_rst",   1'b0, 1'b1, 1'b0, 1'b1, 4'h0, 1'b0, 4'h0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step($sformatf("rm_div1_%0d", i), 1'b1, 1'b1, 1'b0, 1'b1, 4'h0,
                 1'b1, 4'h0, 1'b1);
        end

        // Two-stage cascade as an 8-bit down counter.
        casc_step("cc_rst",  1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        casc_step("cc_load", 1'b1, 1'b1, 1'b1, 8'h02, 1'b0, 1'b0, 8'h02, 1'b0);
        casc_step("cc_01",   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h01, 1'b0);
        casc_step("cc_00",   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'h00, 1'b0);
        casc_step("cc_ff",   1'b1, 1'b1, 1'b0, 8'h00, 1'b1, 1'b1, 8'hFF, 1'b1);
        casc_step("cc_fe",   1'b1, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 8'hFE, 1'b0);
        check("cc_lo_done", {7'd0, lo_done}, 8'h00);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/down_counter_4_bit.md
# down_counter_4_bit

Synchronous 4-bit down counter with parallel load, count enable, borrow-out and a selectable wrap/auto-reload mode. It is the count-down counterpart of the team's 4-bit up counter. It cascades the same way: the borrow-out of one stage drives the enable of the next. It serves as the divider and terminal-count timer in the clocking and timing blocks.

## Interface
- WIDTH, 4, counter width in bits; all arithmetic is modulo 2^WIDTH.
- CLK  input  1  system clock; every register updates on the rising edge.
- RESET  input  1  reset, synchronous and active-low; sampled on the rising edge of CLK.
- EN  input  1  count enable; also serves as borrow-in when cascaded.
- LOAD  input  1  parallel load strobe.
- D_IN  input  WIDTH  load value; also captured as the reload value.
- MODE  input  1  0 = free-run wrap (0 to all-ones), 1 = auto-reload (0 to the captured reload value).
- Q  output  WIDTH  current count, registered.
- BO  output  1  borrow-out, combinational; feeds EN of the next stage.
- DONE  output  1  registered one-cycle terminal-count pulse.

## Operation
- Internal state: Q (WIDTH bits), RLD (the reload register, WIDTH bits), DONE (1 bit). No other storage.
- Per-edge priority: RESET low, then LOAD, then EN, then hold.
- RESET = 0: Q <= 0, RLD <= 0, DONE <= 0. LOAD and EN are ignored.
- LOAD = 1: Q <= D_IN, RLD <= D_IN, DONE <= 0. EN is ignored that cycle, so no decrement and no borrow.
- EN = 1 and Q != 0: Q <= Q - 1, DONE <= 0.
- EN = 1 and Q == 0 (terminal count):
  - With MODE = 0: Q <= all-ones.
  - With MODE = 1: Q <= RLD.
  - In both modes, DONE <= 1.
- EN = 0: Q and RLD hold, DONE <= 0.
- DONE is high for exactly one cycle per terminal count, even with EN held high continuously.
- RLD changes only on LOAD or reset. MODE can change at any time and takes effect at the next terminal count.
- BO = RESET & EN & ~LOAD & (Q == 0). It is purely combinational from the inputs and Q, and has no registered delay.
- Cascading: stage k+1 EN = stage k BO. Two stages in MODE = 0 form an 8-bit down counter. Only the least-significant stage uses LOAD/D_IN semantics independently; to load all stages, LOAD is shared.
- Boundary cases:
  - RLD = 0 with MODE = 1: Q stays 0. BO = EN and DONE asserts on every enabled cycle, so the block divides by 1.
  - RLD = N with MODE = 1: the period is N+1 enabled cycles.
  - MODE = 0: the period is 2^WIDTH enabled cycles.
  - LOAD with D_IN = 0: Q = 0 next cycle, with no DONE for the load itself.

## Timing
- Q latency is 1 cycle from the sampling edge. There are no multicycle paths.
- BO is valid in the same cycle as Q == 0 and EN. It must settle before the next edge of the shared CLK.
- The DONE pulse coincides with the cycle in which Q first shows the reloaded or wrapped value.
- Reset mid-count: the edge that samples RESET = 0 forces Q = 0 and DONE = 0, and cancels any pending terminal count. BO is 0 while RESET = 0.
- First count after reset release with EN = 1: Q = 0 produces BO = 1 that cycle. The next edge wraps or reloads and pulses DONE.
- Simultaneous LOAD and terminal count: LOAD wins. There is no DONE and BO = 0.

## Test plan
- Reset: hold RESET = 0 with LOAD = 1, EN = 1, D_IN = 4'h9 for 2 edges -> Q = 0, DONE = 0, BO = 0 throughout. Release -> Q stays 0 until EN.
- Free-run: MODE = 0, EN = 1 from Q = 0 -> Q sequence 0, F, E, ..., 1, 0, F. BO = 1 only in the Q = 0 cycles. DONE = 1 in the cycles where Q = F.
- Auto-reload: LOAD D_IN = 3, then MODE = 1, EN = 1 -> Q sequence 3, 2, 1, 0, 3, 2, ... DONE pulses every 4th cycle. With EN toggled 1, 0, 1, 0 -> Q holds during the EN = 0 cycles.
- Load collision: Q = 0, EN = 1, LOAD = 1, D_IN = 7 -> Q = 7 next cycle, DONE = 0, BO = 0 during the collision cycle.
- Cascade: two instances, MODE = 0, shared LOAD of 8'h02 with EN = 1 -> combined count 02, 01, 00, FF, FE. The high stage decrements only when low BO = 1. The high-stage DONE pulses once, at the 00 to FF transition.
- Reset mid-operation: MODE = 1, RLD = 5, Q = 2, pulse RESET = 0 for one edge -> Q = 0, RLD = 0, DONE = 0. Then EN = 1 -> Q stays 0, with DONE = 1 on every cycle.
